// File: rtl/apb_slave_mem.sv
// APB slave with a byte-wide register memory, a fixed number of wait states,
// an out-of-range error response and a saturating error counter.
module apb_slave_mem #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    output logic [7:0] err_count
);

    // state | meaning
    // IDLE  | no transfer; waits for PSEL=1, PENABLE=0
    // SETUP | address/data latched, one cycle
    // WAIT  | PREADY low, counter runs down while PSEL & PENABLE
    // DONE  | PREADY high, memory write / error count at end of cycle

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nx;
    logic [7:0]    addr_q;
    logic [7:0]    wdata_q;
    logic          write_q;
    logic [7:0]    mem [DEPTH];
    logic          in_range;
    logic          start;
    logic [AW-1:0] idx;

    assign start    = PSEL && !PENABLE;
    assign in_range = ({24'd0, addr_q} < 32'(DEPTH));
    assign idx      = addr_q[AW-1:0];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (start) state_nx = SETUP;
            end
            SETUP: begin
                if (!PSEL) begin
                    state_nx = IDLE;
                end else if (WAIT_STATES == 0) begin
                    state_nx = DONE;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = 4'(WAIT_STATES);
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end else if (PENABLE) begin
                    if (cnt <= 4'd1) begin
                        state_nx = DONE;
                        cnt_nx   = 4'd0;
                    end else begin
                        cnt_nx = cnt - 4'd1;
                    end
                end
            end
            DONE: begin
                state_nx = start ? SETUP : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= 8'd0;
            wdata_q   <= 8'd0;
            write_q   <= 1'b0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            PRDATA    <= 8'd0;
            err_count <= 8'd0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if ((state == IDLE || state == DONE) && start) begin
                addr_q  <= PADDR;
                wdata_q <= PWDATA;
                write_q <= PWRITE;
            end
            // Outputs are registered on entry to DONE so they are clean for the whole cycle.
            PREADY  <= (state_nx == DONE);
            PSLVERR <= (state_nx == DONE) && !in_range;
            PRDATA  <= (state_nx == DONE && !write_q && in_range) ? mem[idx] : 8'd0;
            if (state == DONE) begin
                if (write_q && in_range) mem[idx] <= wdata_q;
                if (PSLVERR && err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: vector table of single transfers plus
// hand-written abort, back-to-back, reset and saturation sequences.
module tb_apb_slave_mem;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata, errc;
    logic       pready, pslverr;
    logic       psel0, penable0, pwrite0;
    logic [7:0] paddr0, pwdata0, prdata0, errc0;
    logic       pready0, pslverr0;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    apb_slave_mem #(.DEPTH(64), .WAIT_STATES(2)) dut (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata),
        .PREADY(pready), .PSLVERR(pslverr), .err_count(errc)
    );

    apb_slave_mem #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable0),
        .PWRITE(pwrite0), .PADDR(paddr0), .PWDATA(pwdata0), .PRDATA(prdata0),
        .PREADY(pready0), .PSLVERR(pslverr0), .err_count(errc0)
    );

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rd;
        logic       err;
        logic [7:0] ec;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One transfer on the WAIT_STATES=2 instance; lat counts cycles from the SETUP-state cycle.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic err, output int lat,
                        output logic quiet);
        quiet = 1'b1;
        lat   = -1;
        rd    = 8'd0;
        err   = 1'b0;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1; paddr = ~a; pwdata = ~d; pwrite = ~w;
        for (int n = 0; n <= 20; n++) begin
            if (n > 0) @(negedge clk);
            if (pready) begin
                lat = n;
                rd  = prdata;
                err = pslverr;
                break;
            end
            if (prdata != 8'd0 || pslverr) quiet = 1'b0;
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        vec_t       vecs [12];
        logic [7:0] rd;
        logic       err, quiet, seen;
        int         lat;
        logic [7:0] exp_ec;

        vecs[0]  = '{1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 8'h40, 8'h3C, 8'h00, 1'b1, 8'd1};
        vecs[3]  = '{1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 8'd2};
        vecs[4]  = '{1'b0, 8'h3F, 8'h00, 8'h00, 1'b0, 8'd2};
        vecs[5]  = '{1'b1, 8'h3F, 8'h5A, 8'h00, 1'b0, 8'd2};
        vecs[6]  = '{1'b0, 8'h3F, 8'h00, 8'h5A, 1'b0, 8'd2};
        vecs[7]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'd2};
        vecs[8]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 8'd2};
        vecs[9]  = '{1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 8'd2};
        vecs[10] = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 8'd3};
        vecs[11] = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 8'd3};

        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'd0; pwdata = 8'd0;
        psel0 = 1'b0; penable0 = 1'b0; pwrite0 = 1'b0; paddr0 = 8'd0; pwdata0 = 8'd0;
        repeat (2) @(negedge clk);
        chk("reset pready", 32'(pready), 32'd0);
        chk("reset pslverr", 32'(pslverr), 32'd0);
        chk("reset prdata", 32'(prdata), 32'd0);
        chk("reset err_count", 32'(errc), 32'd0);
        chk("reset dut0 pready", 32'(pready0), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            xfer(vecs[i].w, vecs[i].a, vecs[i].d, rd, err, lat, quiet);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d prdata", i), 32'(rd), 32'(vecs[i].rd));
            chk($sformatf("vec%0d pslverr", i), 32'(err), 32'(vecs[i].err));
            chk($sformatf("vec%0d quiet before ready", i), 32'(quiet), 32'd1);
            @(negedge clk);
            chk($sformatf("vec%0d err_count", i), 32'(errc), 32'(vecs[i].ec));
        end

        // PSEL with PENABLE already high from IDLE is not a transfer start.
        @(negedge clk);
        psel = 1'b1; penable = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen |= pready;
        end
        psel = 1'b0; penable = 1'b0;
        chk("idle protocol violation pready", 32'(seen), 32'd0);

        // Abort: PSEL drops in the second WAIT cycle of a write.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h77;
        @(negedge clk);
        penable = 1'b1;
        seen = pready;
        @(negedge clk);
        seen |= pready;
        @(negedge clk);
        psel = 1'b0;
        seen |= pready;
        repeat (5) begin
            @(negedge clk);
            penable = 1'b0;
            seen |= pready;
        end
        chk("abort pready", 32'(seen), 32'd0);
        chk("abort err_count", 32'(errc), 32'd3);
        xfer(1'b0, 8'h02, 8'h00, rd, err, lat, quiet);
        chk("abort readback latency", 32'(lat), 32'd3);
        chk("abort readback prdata", 32'(rd), 32'h00);

        // Back-to-back write then read on the zero-wait instance.
        @(negedge clk);
        psel0 = 1'b1; penable0 = 1'b0; pwrite0 = 1'b1; paddr0 = 8'h05; pwdata0 = 8'h11;
        @(negedge clk);
        penable0 = 1'b1; paddr0 = 8'h06; pwdata0 = 8'h22;
        chk("b2b setup pready", 32'(pready0), 32'd0);
        @(negedge clk);
        chk("b2b write pready", 32'(pready0), 32'd1);
        chk("b2b write pslverr", 32'(pslverr0), 32'd0);
        chk("b2b write prdata", 32'(prdata0), 32'd0);
        penable0 = 1'b0; pwrite0 = 1'b0; paddr0 = 8'h05;
        @(negedge clk);
        chk("b2b read setup pready", 32'(pready0), 32'd0);
        penable0 = 1'b1;
        @(negedge clk);
        chk("b2b read pready", 32'(pready0), 32'd1);
        chk("b2b read prdata", 32'(prdata0), 32'h11);
        psel0 = 1'b0; penable0 = 1'b0;
        @(negedge clk);
        chk("b2b after pready", 32'(pready0), 32'd0);

        // Reset pulse during WAIT of a write of 0x99 to 0x01.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'h99;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-wait reset pready", 32'(pready), 32'd0);
        chk("mid-wait reset pslverr", 32'(pslverr), 32'd0);
        chk("mid-wait reset prdata", 32'(prdata), 32'd0);
        chk("mid-wait reset err_count", 32'(errc), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 8'h01, 8'h00, rd, err, lat, quiet);
        chk("post-reset read latency", 32'(lat), 32'd3);
        chk("post-reset read 0x01", 32'(rd), 32'h00);
        xfer(1'b0, 8'h10, 8'h00, rd, err, lat, quiet);
        chk("post-reset read 0x10", 32'(rd), 32'h00);

        // Out-of-range reads drive err_count into saturation.
        exp_ec = 8'd0;
        for (int i = 0; i < 300; i++) begin
            xfer(1'b0, 8'h80, 8'h00, rd, err, lat, quiet);
            exp_ec = (exp_ec == 8'hFF) ? 8'hFF : exp_ec + 8'd1;
            chk($sformatf("sat%0d latency", i), 32'(lat), 32'd3);
            chk($sformatf("sat%0d prdata", i), 32'(rd), 32'h00);
            chk($sformatf("sat%0d pslverr", i), 32'(err), 32'd1);
            @(negedge clk);
            chk($sformatf("sat%0d err_count", i), 32'(errc), 32'(exp_ec));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning number of 8-bit memory locations (legal 1..256).
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, meaning access-phase cycles with PREADY low before completion (legal 0..15).
REQ-003 The block SHALL have port PCLK, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port PRESETn, input, 1, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port PSEL, input, 1, meaning slave selected by the upstream APB master.
REQ-006 The block SHALL have port PENABLE, input, 1, meaning access phase of the transfer.
REQ-007 The block SHALL have port PWRITE, input, 1, meaning 1 = write, 0 = read.
REQ-008 The block SHALL have port PADDR, input, 8, meaning location address.
REQ-009 The block SHALL have port PWDATA, input, 8, meaning write data.
REQ-010 The block SHALL have port PRDATA, output, 8, meaning read data, valid only while PREADY=1 on a read.
REQ-011 The block SHALL have port PREADY, output, 1, meaning transfer completes this cycle.
REQ-012 The block SHALL have port PSLVERR, output, 1, meaning error response, valid only while PREADY=1.
REQ-013 The block SHALL have port err_count, output, 8, meaning saturating count of completed error transfers.

Function
REQ-014 The block SHALL implement states IDLE, SETUP, WAIT, DONE.
REQ-015 IDLE→SETUP SHALL occur on a rising edge sampling PSEL=1, PENABLE=0; PADDR, PWRITE and PWDATA SHALL be latched at that edge.
REQ-016 SETUP SHALL last one cycle, then go to WAIT with the wait counter loaded to WAIT_STATES, or to DONE directly if WAIT_STATES=0.
REQ-017 WAIT SHALL decrement the counter each cycle with PSEL=1 and PENABLE=1, and go to DONE the cycle after the counter reaches 1.
REQ-018 PREADY SHALL be 1 only in DONE; for a setup cycle T, PREADY SHALL be 1 in cycle T+1+WAIT_STATES and 0 in all other cycles.
REQ-019 An address is out of range when the latched PADDR >= DEPTH; such a transfer SHALL give PSLVERR=1 in DONE and SHALL NOT modify memory.
REQ-020 In-range write: mem[addr] SHALL take the latched PWDATA at the edge that ends DONE; PSLVERR SHALL be 0.
REQ-021 In-range read: PRDATA SHALL equal mem[addr] during DONE, including data written by the immediately preceding transfer.
REQ-022 PRDATA SHALL be 0x00 whenever PREADY=0, on every write, and on every error read.
REQ-023 err_count SHALL increment by 1 at the end of each DONE with PSLVERR=1, and SHALL saturate at 0xFF.
REQ-024 From DONE, sampling PSEL=1, PENABLE=0 SHALL go to SETUP (back-to-back transfer, no idle cycle); any other input SHALL go to IDLE.
REQ-025 Abort: PSEL=0 sampled in SETUP or WAIT SHALL return the block to IDLE with no memory write, no PREADY pulse and no err_count change.
REQ-026 Protocol violation: PSEL=1 with PENABLE=1 sampled in IDLE SHALL be ignored, and the block SHALL stay in IDLE.
REQ-027 During SETUP/WAIT/DONE, input changes on PADDR, PWRITE and PWDATA SHALL NOT affect the transfer; latched values SHALL be used.

Reset
REQ-028 PRESETn=0 SHALL immediately force state IDLE, PREADY=0, PSLVERR=0, PRDATA=0x00, err_count=0x00, wait counter 0, and all memory locations 0x00.
REQ-029 Reset asserted mid-transfer SHALL abort it without a memory write; the first transfer after PRESETn rises SHALL behave as one from IDLE.
REQ-030 Reset deassertion SHALL take effect at the first rising PCLK edge after PRESETn returns to 1.

Verification
REQ-031 Write 0xA5 to address 0x10, then read 0x10 (WAIT_STATES=2) -> each transfer has PREADY high exactly 3 cycles after setup, the read returns PRDATA=0xA5, and PSLVERR=0.
REQ-032 Write 0x3C to address 0x40 (DEPTH=64) -> PSLVERR=1 with PREADY, err_count=1, and reading any location still returns 0x00.
REQ-033 Back-to-back write 0x11 to 0x05 then read 0x05 with no idle cycle (WAIT_STATES=0) -> PREADY high on both access cycles, read PRDATA=0x11.
REQ-034 PSEL drops in the second WAIT cycle of a write of 0x77 to 0x02 -> no PREADY pulse, and a later read of 0x02 returns 0x00.
REQ-035 300 consecutive out-of-range reads -> err_count stops at 0xFF, and PRDATA=0x00 on every completion.
REQ-036 PRESETn pulsed low during WAIT of a write of 0x99 to 0x01 -> outputs zero at once, and a read of 0x01 after reset returns 0x00.
